// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (8N1 by default).
//
// The serial input passes through a two-flop synchronizer. An FSM, advanced
// only on baud_tick, then finds the start bit, samples each bit at its middle
// and checks the stop bit.
//
// Ports
//   sys_clk    in   system clock; all logic uses its rising edge
//   reset      in   synchronous, active-low reset
//   baud_tick  in   one-cycle enable pulse at OVERSAMPLE x baud rate
//   rx         in   asynchronous serial line (idles high)
//   rx_data    out  last correctly framed word; holds until the next good frame
//   rx_valid   out  one-cycle pulse: rx_data has just been updated
//   frame_err  out  one-cycle pulse: the stop bit was sampled low
//   busy       out  high in every state except IDLE
//   fsm_state  out  current FSM state encoding (debug visibility)
//
// Output handshake: rx_valid is a single-cycle strobe with no ready/back-pressure.
// rx_data is stable from the edge that raises rx_valid until the next good frame.
// rx_valid and frame_err are mutually exclusive.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [2:0]           fsm_state
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] MID      = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic [DATA_BITS:0]   sh_ext;
  logic                 valid_n, err_n;
  logic                 rx_meta, rx_s;
  logic [1:0]           settle;
  logic                 armed, armed_n;

  // Synchronizer. Both flops reset high, so rx_s does not reflect the real
  // line until two edges after reset release. settle[1] marks that point.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      settle  <= 2'b00;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      settle  <= {settle[0], 1'b1};
    end
  end

  // Shift new samples in at the MSB, so the first bit received (the LSB)
  // ends up in bit 0 after DATA_BITS shifts.
  assign sh_ext = {rx_s, shreg};

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    data_n    = rx_data;
    armed_n   = armed;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    if (baud_tick) begin
      // A reset in mid-frame may leave the line low. 'armed' blocks start
      // detection until the settled line has been seen high, so a new frame
      // needs a fresh falling edge.
      armed_n = armed | (settle[1] & rx_s);
      unique case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state_n   = START;
            cnt_n     = '0;
            bit_idx_n = '0;
          end
        end
        START: begin
          if (cnt == MID) begin
            cnt_n   = '0;
            state_n = rx_s ? IDLE : DATA;  // high at mid-start is a glitch
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt_n   = '0;
            shreg_n = sh_ext[DATA_BITS:1];
            if (bit_idx == BIT_LAST) begin
              bit_idx_n = '0;
              state_n   = STOP;
            end else begin
              bit_idx_n = bit_idx + BW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt_n = '0;
            if (rx_s) begin
              data_n  = shreg;
              valid_n = 1'b1;
              state_n = IDLE;
            end else begin
              err_n   = 1'b1;
              state_n = BREAK;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        BREAK: begin
          // Wait out a held-low line so it reports only one frame_err.
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= err_n;
      armed     <= armed_n;
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per frame, sent LSB first.
REQ-002 Parameter OVERSAMPLE, default 16: baud_tick pulses per bit period; must be even and at least 8.
REQ-003 Port sys_clk, input, 1: system clock; all logic rises on its positive edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset; sampled on the rising edge of sys_clk.
REQ-005 Port baud_tick, input, 1: one-sys_clk-wide enable pulse at OVERSAMPLE x baud rate, driven by baud_gen.
REQ-006 Port rx, input, 1: asynchronous serial line; idles high.
REQ-007 Port rx_data, output, DATA_BITS: last correctly framed byte; holds its value until the next good frame.
REQ-008 Port rx_valid, output, 1: one-cycle pulse marking that rx_data has just been updated.
REQ-009 Port frame_err, output, 1: one-cycle pulse on a stop-bit error.
REQ-010 Port busy, output, 1: high in every state except IDLE.

Function
REQ-011 rx shall pass through a two-flop synchronizer to form rx_s; all decisions use rx_s, so there are 2 sys_clk of input latency.
REQ-012 The FSM states shall be IDLE, START, DATA, STOP and BREAK.
REQ-013 State advances and the tick counter shall change only on sys_clk edges where baud_tick=1, except the single-cycle output pulses.
REQ-014 The tick counter shall run 0..OVERSAMPLE-1 and wrap to 0.
REQ-015 The middle sample point shall be tick count OVERSAMPLE/2-1, which is 7 at the default.
REQ-016 IDLE: on a tick with rx_s=0, go to START with the count cleared; otherwise stay in IDLE.
REQ-017 START: at the middle sample, if rx_s=0, clear the count and go to DATA.
REQ-018 START: at the middle sample, if rx_s=1, treat it as a glitch and return to IDLE with no output pulse.
REQ-019 DATA: sample rx_s at each count OVERSAMPLE-1 after the middle of start, i.e. one bit period apart, and shift it into the MSB of the shift register (LSB-first assembly).
REQ-020 DATA: after DATA_BITS samples, go to STOP; the bit index runs 0..DATA_BITS-1.
REQ-021 STOP: at the stop middle sample, if rx_s=1, load rx_data from the shift register, pulse rx_valid, and go to IDLE.
REQ-022 STOP: at the stop middle sample, if rx_s=0, pulse frame_err, leave rx_data unchanged, and go to BREAK.
REQ-023 BREAK: stay until a tick with rx_s=1, then go to IDLE; a held-low line therefore yields exactly one frame_err.
REQ-024 rx_valid and frame_err shall assert on the same edge the stop sample is taken, last exactly one sys_clk, and never assert together.
REQ-025 A new start bit shall be accepted on the first tick after returning to IDLE, which supports back-to-back frames with one stop bit.
REQ-026 When baud_tick is low, all state, counters and outputs shall hold, apart from clearing the pulse outputs.
REQ-027 rx transitions mid-frame between sample points shall have no effect.

Reset
REQ-028 With reset=0 at a sys_clk edge, the FSM shall go to IDLE and clear all counters.
REQ-029 The same reset shall clear rx_data to 0, rx_valid to 0, frame_err to 0 and busy to 0, and set both synchronizer flops to 1.
REQ-030 Reset shall take precedence over baud_tick.
REQ-031 Reset asserted mid-frame shall abort the frame with no rx_valid or frame_err pulse; after release, the block shall wait for a fresh falling edge.

Verification
REQ-032 Setup: sys_clk 25 MHz, baud_tick every 4 sys_clk; send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) with stop=1 -> one rx_valid pulse, rx_data=0xA5, frame_err never high.
REQ-033 Send 0x00 then 0xFF back-to-back with no idle gap -> two rx_valid pulses, 16x4x10=640 sys_clk apart, with data 0x00 then 0xFF.
REQ-034 Drive a 3-tick low glitch on an idle line -> busy rises, then returns to 0 by the start middle sample; no rx_valid and no frame_err.
REQ-035 Send 0x3C with stop=0 and hold rx low for 3 bit times, then release -> exactly one frame_err pulse, rx_data keeps its previous value, busy stays high until rx returns high, then a following 0x55 frame is received correctly.
REQ-036 Assert reset=0 for 2 cycles during data bit 4 of a frame, then send 0x81 -> no pulse for the aborted frame, then rx_valid with rx_data=0x81.
REQ-037 Hold baud_tick=0 for 100 cycles mid-frame, then resume -> the frame still decodes to its correct value.
